dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the M stage of the pipelined RV32 core. It accepts the load/store request the M stage presents and returns `readDataM`, which the MEM/WB register captures. It holds the pipeline with `stallM` for a fixed number of wait states, performs byte/half/word lane selection with sign or zero extension, and merges stores with byte granularity into a single-port word array.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; must be a power of two.
- `WAIT_CYCLES`, 2: extra wait states per access, 0..15.

Ports:
- `CLK`  in  1  clock; everything updates on the rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `memReadM`  in  1  load request.
- `memWriteM`  in  1  store request.
- `funct3M`  in  3  access size and extension (RV32 load/store encoding).
- `aluResultM`  in  32  byte address.
- `writeDataM`  in  32  store data, right-aligned.
- `readDataM`  out  32  load result, registered.
- `stallM`  out  1  pipeline hold; the request must stay stable while it is high.
- `misalignM`  out  1  misaligned-access flag; see Configuration.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - A request (`memReadM | memWriteM`) drives `stallM` high combinationally.
  - The next state is WAIT with the counter loaded to `WAIT_CYCLES-1`.
  - If `WAIT_CYCLES==0`, the access is performed on this edge and the next state is RESP.
- WAIT:
  - `stallM`=1 and the counter decrements each cycle.
  - On the edge where the counter is 0, the array access is performed and the next state is RESP.
- RESP:
  - `stallM`=0, so the pipeline advances on this edge and MEM/WB captures `readDataM`.
  - The next state is always IDLE. The still-present request is not re-accepted.
- Index is `aluResultM[log2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so addresses wrap.
- Loads (little-endian):
  - 000 LB and 100 LBU select a byte.
  - 001 LH and 101 LHU select a halfword.
  - 010 LW returns the full word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Stores:
  - 000 SB writes one byte from `writeDataM[7:0]`.
  - 001 SH writes two bytes from `writeDataM[15:0]`.
  - 010 SW writes the word.
  - Bytes that are not enabled are preserved.
- Illegal `funct3`: the access is suppressed, it takes the normal latency, and loads return 0.
- `memReadM` and `memWriteM` both high: treated as a store, and `readDataM` is unchanged.
- `readDataM` updates only when a load completes and holds otherwise. Stores never modify it.
- Each accepted store writes exactly once.

## Timing
- Reset values: state IDLE, counter 0, `readDataM`=0, `misalignM`=0.
- While `RST` is high, `stallM` is forced to 0.
- Latency: `stallM` is high for `WAIT_CYCLES+1` cycles starting with the request cycle, followed by one RESP cycle. With default parameters, a request occupies 4 cycles total.
- Back-to-back requests: a new request is seen in the IDLE cycle after RESP. There is no gap beyond that cycle.
- Reset mid-operation: `RST` in WAIT returns the FSM to IDLE and the pending store is not performed. Array contents are never cleared by reset.
- The array is read and written synchronously on the access edge. There is no read-during-write hazard, because there is one access per request.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are detected: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - On detection, IDLE goes directly to RESP (one stall cycle).
  - The access is suppressed, `readDataM` is 0, and `misalignM`=1 for the RESP cycle only.
- Undefined:
  - `misalignM` is tied to 0.
  - Low address bits below the access size are masked, giving an aligned access with normal latency.

## Structure
- `dmem_pkg` holds the `funct3` localparams (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state typedef.
- One sub-module, `dmem_lane_fmt`, is combinational:
  - load path: byte/half extraction plus extension;
  - store path: byte-enable generation plus data replication.
- The FSM, counter and array stay in `dmem_responder`.

## Test plan
All scenarios use default parameters unless stated.
- SW 0xDEADBEEF @0x10, then LW @0x10 → `readDataM`=0xDEADBEEF in RESP. `stallM` is high for exactly 3 cycles per access.
- After that store: LB @0x13 → 0xFFFFFFDE; LBU @0x12 → 0x000000AD; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- SB 0x000000AA @0x11, then LW @0x10 → 0xDEADAAEF. SH 0x1234 @0x12, then LW → 0x1234AAEF.
- SW 0x55 @0x20 with `RST` pulsed during WAIT, then LW @0x20 → old contents. After reset, `readDataM`=0 and `stallM`=0.
- LW @0x12:
  - With the macro: 1 stall cycle, `misalignM`=1, `readDataM`=0.
  - Without the macro: returns the word @0x10 with `misalignM`=0.
- `WAIT_CYCLES`=0, back-to-back SW @0x0 then LW @0x0 → each access stalls 1 cycle and the LW returns the stored value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the M-stage data-memory responder: RV32 load/store
// funct3 encodings, FSM state type and the misalignment predicate.
package dmem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Stores share their encodings with LB/LH/LW, so this covers SH and SW too.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3)
      LH, LHU: return addr_lo[0];
      LW:      return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: load byte/half extraction with sign or zero
// extension, and store byte-enable generation with data replication.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        load_ok,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Sub-size low address bits are ignored (masked) for halves and words.
  assign lane_byte = rword[{addr_lo, 3'b000} +: 8];
  assign lane_half = addr_lo[1] ? rword[31:16] : rword[15:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    load_data = '0;
    load_ok   = 1'b1;
    case (funct3)
      LB:      load_data = {{24{lane_byte[7]}}, lane_byte};
      LBU:     load_data = {24'h0, lane_byte};
      LH:      load_data = {{16{lane_half[15]}}, lane_half};
      LHU:     load_data = {16'h0, lane_half};
      LW:      load_data = rword;
      default: load_ok = 1'b0;
    endcase
  end

  always_comb begin
    byte_en    = 4'b0000;
    store_data = wdata;
    case (funct3)
      SB: begin
        byte_en    = 4'b0001 << addr_lo;
        store_data = {4{wdata[7:0]}};
      end
      SH: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
      end
      SW:      byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: fixed wait-state FSM, byte-granular stores and
// a registered load result. Optional misaligned-access trap: DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] aluResultM,
  input  logic [31:0] writeDataM,
  output logic [31:0] readDataM,
  output logic        stallM,
  output logic        misalignM
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [AW-1:0]  idx;
  logic           request, is_store, is_load;
  logic           misaligned, do_access, trap;
  logic [31:0]    load_data, store_data;
  logic           load_ok;
  logic [3:0]     byte_en;
  logic           unused_addr;

  // NOTE: the array has no reset; contents survive RST and only stores change them.
  logic [31:0] mem [DEPTH_WORDS];

  assign idx         = aluResultM[AW+1:2];
  assign unused_addr = &{1'b0, aluResultM[31:AW+2]};
  assign request     = memReadM | memWriteM;
  assign is_store    = memWriteM;
  assign is_load     = memReadM & ~memWriteM;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(funct3M, aluResultM[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  dmem_lane_fmt u_lane_fmt (
    .funct3     (funct3M),
    .addr_lo    (aluResultM[1:0]),
    .rword      (mem[idx]),
    .wdata      (writeDataM),
    .load_data  (load_data),
    .load_ok    (load_ok),
    .byte_en    (byte_en),
    .store_data (store_data)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stallM    = 1'b0;
    do_access = 1'b0;
    trap      = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          stallM = 1'b1;
          if (misaligned) begin
            trap      = 1'b1;
            state_nxt = RESP;
          end else if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CNT_LOAD;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stallM = 1'b1;
        if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      // The request is still present here; returning to IDLE without looking
      // at it keeps one access per request.
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Reset wins on the same edge, so a store pending in WAIT is dropped.
    if (RST) begin
      stallM    = 1'b0;
      do_access = 1'b0;
      trap      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      readDataM <= 32'h0;
      misalignM <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      misalignM <= trap;
      if (trap && is_load)
        readDataM <= 32'h0;
      else if (do_access && is_load)
        readDataM <= load_ok ? load_data : 32'h0;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_access && is_store) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) mem[idx][8*b +: 8] <= store_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default-parameter instance plus a
// zero-wait-state instance, with hand-computed expected values.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        rd0, wr0, rd1, wr1;
  logic [2:0]  f30, f31;
  logic [31:0] a0, a1, wd0, wd1;
  logic [31:0] rdata0, rdata1;
  logic        stall0, stall1, mis0, mis1;

  int checks;
  int errors;

  dmem_responder u_dut (
    .CLK        (clk),
    .RST        (rst),
    .memReadM   (rd0),
    .memWriteM  (wr0),
    .funct3M    (f30),
    .aluResultM (a0),
    .writeDataM (wd0),
    .readDataM  (rdata0),
    .stallM     (stall0),
    .misalignM  (mis0)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
    .CLK        (clk),
    .RST        (rst),
    .memReadM   (rd1),
    .memWriteM  (wr1),
    .funct3M    (f31),
    .aluResultM (a1),
    .writeDataM (wd1),
    .readDataM  (rdata1),
    .stallM     (stall1),
    .misalignM  (mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (sel == 0) begin
      rd0 = rd; wr0 = wr; f30 = f3; a0 = addr; wd0 = wd;
    end else begin
      rd1 = rd; wr1 = wr; f31 = f3; a1 = addr; wd1 = wd;
    end
  endtask

  // Presents a request in an IDLE cycle, counts stall cycles (bounded) and
  // returns in the RESP cycle with the registered result sampled.
  task automatic access(input string tag, input int sel, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_stalls, output logic [31:0] rdata, output logic mis);
    int stalls;
    @(negedge clk);
    drive(sel, rd, wr, f3, addr, wd);
    #1;
    stalls = 0;
    while (((sel == 0) ? stall0 : stall1) && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stalls"}, stalls, exp_stalls);
    rdata = (sel == 0) ? rdata0 : rdata1;
    mis   = (sel == 0) ? mis0 : mis1;
  endtask

  logic [31:0] r;
  logic        m;
  int          norm;

  initial begin
    checks = 0;
    errors = 0;
    norm   = 3;
    rst    = 1'b1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    // Reset state, with a request present to show stallM is forced low.
    repeat (2) @(negedge clk);
    rd0 = 1'b1;
    #1;
    check("rst_stall_forced", {31'h0, stall0}, 32'h0);
    check("rst_rdata", rdata0, 32'h0);
    check("rst_misalign", {31'h0, mis0}, 32'h0);
    @(negedge clk);
    rd0 = 1'b0;
    rst = 1'b0;

    // Word store/load round trip.
    access("sw_10", 0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, norm, r, m);
    access("lw_10", 0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, norm, r, m);
    check("lw_10_data", r, 32'hDEADBEEF);
    check("lw_10_mis", {31'h0, m}, 32'h0);

    // Lane selection and extension.
    access("lb_13", 0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, norm, r, m);
    check("lb_13_data", r, 32'hFFFFFFDE);
    access("lbu_12", 0, 1'b1, 1'b0, 3'b100, 32'h12, 32'h0, norm, r, m);
    check("lbu_12_data", r, 32'h000000AD);
    access("lh_12", 0, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, norm, r, m);
    check("lh_12_data", r, 32'hFFFFDEAD);
    access("lhu_10", 0, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0, norm, r, m);
    check("lhu_10_data", r, 32'h0000BEEF);

    // Byte and half stores merge; a store leaves readDataM untouched.
    access("sb_11", 0, 1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFFFFAA, norm, r, m);
    check("sb_keeps_rdata", r, 32'h0000BEEF);
    access("lw_sb", 0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, norm, r, m);
    check("lw_sb_data", r, 32'hDEADAAEF);
    access("sh_12", 0, 1'b0, 1'b1, 3'b001, 32'h12, 32'hFFFF1234, norm, r, m);
    access("lw_sh", 0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, norm, r, m);
    check("lw_sh_data", r, 32'h1234AAEF);

    // Illegal funct3 load returns 0 with normal latency.
    access("ill_ld", 0, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, norm, r, m);
    check("ill_ld_data", r, 32'h0);

    // Read and write together behave as a store.
    access("rdwr_14", 0, 1'b1, 1'b1, 3'b010, 32'h14, 32'hCAFEF00D, norm, r, m);
    check("rdwr_keeps_rdata", r, 32'h0);
    access("lw_14", 0, 1'b1, 1'b0, 3'b010, 32'h14, 32'h0, norm, r, m);
    check("lw_14_data", r, 32'hCAFEF00D);

    // Upper address bits ignored: 0x1010 aliases 0x10.
    access("lw_wrap", 0, 1'b1, 1'b0, 3'b010, 32'h1010, 32'h0, norm, r, m);
    check("lw_wrap_data", r, 32'h1234AAEF);

    // Reset on the would-be access edge drops the pending store.
    access("sw_20", 0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h11111111, norm, r, m);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h00000055);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_stall", {31'h0, stall0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    check("midrst_rdata", rdata0, 32'h0);
    check("midrst_stall_after", {31'h0, stall0}, 32'h0);
    access("lw_20", 0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, norm, r, m);
    check("lw_20_data", r, 32'h11111111);

    // Misaligned word load.
`ifdef DMEM_MISALIGN_TRAP_EN
    access("lw_12", 0, 1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 1, r, m);
    check("lw_12_data", r, 32'h0);
    check("lw_12_mis", {31'h0, m}, 32'h1);
`else
    access("lw_12", 0, 1'b1, 1'b0, 3'b010, 32'h12, 32'h0, norm, r, m);
    check("lw_12_data", r, 32'h1234AAEF);
    check("lw_12_mis", {31'h0, m}, 32'h0);
`endif
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    check("mis_one_cycle", {31'h0, mis0}, 32'h0);

    // Zero wait states, back-to-back.
    access("w0_sw_0", 1, 1'b0, 1'b1, 3'b010, 32'h0, 32'h89ABCDEF, 1, r, m);
    access("w0_lw_0", 1, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1, r, m);
    check("w0_lw_0_data", r, 32'h89ABCDEF);
    access("w0_lbu_1", 1, 1'b1, 1'b0, 3'b100, 32'h1, 32'h0, 1, r, m);
    check("w0_lbu_1_data", r, 32'h000000CD);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
